eep_prog_ctrl: RTL and testbench
================================

EEP_PROG_CTRL -- requirements
Module: eep_prog_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 12: memory word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 2: address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter PUMP_CYCLES, default 1400000: clocks chrg_pmp_en must be held per program (3 ms).
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port por_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port eep_cs_n  input  1: bus chip select, active-low.
REQ-007 SHALL have port eep_r_w_n  input  1: 1 = read, 0 = write.
REQ-008 SHALL have port eep_addr  input  ADDR_W: bus word address.
REQ-009 SHALL have port wrt_data  input  DATA_W: bus write data.
REQ-010 SHALL have port chrg_pmp_en  input  1: charge pump enable, driven by the system.
REQ-011 SHALL have port rd_data  output  DATA_W: registered read data.
REQ-012 SHALL have port rd_vld  output  1: one-cycle pulse, rd_data updated.
REQ-013 SHALL have port busy  output  1: program cycle in progress.
REQ-014 SHALL have port wrt_done  output  1: one-cycle pulse, program cycle finished (good or bad).
REQ-015 SHALL have port wrt_err  output  1: sticky, last program cycle failed.
REQ-016 SHALL have port wrt_rej  output  1: one-cycle pulse, bus access refused while busy.

Function
REQ-017 SHALL hold 2**ADDR_W words of DATA_W bits in a register array that por_n does not clear (non-volatile).
REQ-018 SHALL implement FSM states IDLE, ARM, PROG, COMMIT; busy = (state != IDLE).
REQ-019 In IDLE, cs_n=0 and r_w_n=0 SHALL capture eep_addr and wrt_data, clear wrt_err, and move to ARM on the same edge (busy high next cycle).
REQ-020 In IDLE, cs_n=0 and r_w_n=1 SHALL load rd_data = mem[eep_addr] and pulse rd_vld on the following cycle (latency 1).
REQ-021 ARM SHALL last one cycle: chrg_pmp_en=1 -> PROG with counter=0; chrg_pmp_en=0 -> COMMIT with fail flag set.
REQ-022 PROG SHALL increment the counter every cycle; chrg_pmp_en=0 on any PROG cycle -> COMMIT with fail flag set.
REQ-023 PROG SHALL go to COMMIT with pass when counter reaches PUMP_CYCLES-1 with chrg_pmp_en=1 (exactly PUMP_CYCLES PROG cycles).
REQ-024 Counter width SHALL be $clog2(PUMP_CYCLES+1); it SHALL never wrap.
REQ-025 COMMIT SHALL last one cycle: on pass write the captured data to the captured address; on fail write all-ones (erased state) there and set wrt_err.
REQ-026 COMMIT SHALL pulse wrt_done and return to IDLE; a new bus access is accepted from the next cycle.
REQ-027 Any bus access (read or write) while busy SHALL be ignored, pulse wrt_rej, and change neither memory nor rd_data.
REQ-028 rd_data SHALL hold its value between reads.
REQ-029 Only one write SHALL be outstanding; no queueing.

Reset
REQ-030 por_n=0 SHALL force state IDLE, counter 0, rd_data 0, rd_vld 0, busy 0, wrt_done 0, wrt_err 0, and wrt_rej 0 immediately.
REQ-031 Reset during ARM/PROG/COMMIT-entry SHALL abort the program cycle and leave the target word unchanged.
REQ-032 Memory contents SHALL survive reset.

Verification (PUMP_CYCLES=8, DATA_W=12, ADDR_W=2)
REQ-033 Write 0xA5C to addr 2 with chrg_pmp_en high throughout -> busy for 10 cycles, wrt_done pulse, wrt_err 0; then read addr 2 -> rd_data 0xA5C, rd_vld 1 cycle after request.
REQ-034 Write 0x123 to addr 1 with chrg_pmp_en low at ARM -> wrt_done after 2 busy cycles, wrt_err 1, read addr 1 -> 0xFFF.
REQ-035 Write 0x456 to addr 3, drop chrg_pmp_en on PROG cycle 5 -> COMMIT next cycle, wrt_err 1, addr 3 reads 0xFFF; next good write clears wrt_err.
REQ-036 Read or write while busy -> wrt_rej pulses, rd_data and the target word unchanged, and the original program completes normally.
REQ-037 Assert por_n=0 mid-PROG of 0x777 to addr 0 previously holding 0x0F0 -> all outputs 0 at once; after release addr 0 reads 0x0F0.
REQ-038 Back-to-back: request a write on the cycle after wrt_done -> accepted, busy reasserts next cycle.

Source files
------------

// File: rtl/eep_prog_ctrl.sv
// -----------------------------------------------------------------------------
// eep_prog_ctrl
// Controller for a small non-volatile word store. Bus reads return a word one
// cycle after the request. A bus write starts a program cycle that needs the
// externally controlled charge pump to stay enabled for PUMP_CYCLES clocks. If
// the pump drops out, the target word is left in the erased (all-ones) state
// and wrt_err is set.
//
// Ports
//   clk          rising-edge clock
//   por_n        asynchronous active-low power-on reset (memory is not cleared)
//   eep_cs_n     bus chip select, active-low
//   eep_r_w_n    1 = read, 0 = write
//   eep_addr     bus word address
//   wrt_data     bus write data
//   chrg_pmp_en  charge pump enable, driven by the system
//   rd_data      registered read data, held between reads
//   rd_vld       one-cycle pulse, rd_data updated
//   busy         program cycle in progress
//   wrt_done     one-cycle pulse, program cycle finished (good or bad)
//   wrt_err      sticky, last program cycle failed
//   wrt_rej      one-cycle pulse, bus access refused while busy
// -----------------------------------------------------------------------------
module eep_prog_ctrl #(
  parameter int DATA_W      = 12,
  parameter int ADDR_W      = 2,
  parameter int PUMP_CYCLES = 1400000
) (
  input  logic              clk,
  input  logic              por_n,
  input  logic              eep_cs_n,
  input  logic              eep_r_w_n,
  input  logic [ADDR_W-1:0] eep_addr,
  input  logic [DATA_W-1:0] wrt_data,
  input  logic              chrg_pmp_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  output logic              busy,
  output logic              wrt_done,
  output logic              wrt_err,
  output logic              wrt_rej
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam int                CNT_W    = $clog2(PUMP_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PUMP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    PROG   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               fail_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic bus_req, wr_req, rd_req, idle;

  assign bus_req = ~eep_cs_n;
  assign wr_req  = bus_req & ~eep_r_w_n;
  assign rd_req  = bus_req &  eep_r_w_n;
  assign idle    = (state_q == IDLE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge por_n) begin
    if (!por_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this purely combinational;
  // any path that left state_d unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_req) state_d = ARM;
      ARM:     state_d = chrg_pmp_en ? PROG : COMMIT;
      PROG:    if (!chrg_pmp_en || cnt_q == CNT_LAST) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy     = (state_q != IDLE);
    wrt_done = (state_q == COMMIT);
  end

  // ---------------------------------------------------------------------------
  // Program-cycle datapath and bus response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge por_n) begin
    if (!por_n) begin
      cnt_q   <= '0;
      fail_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_data <= '0;
      rd_vld  <= 1'b0;
      wrt_err <= 1'b0;
      wrt_rej <= 1'b0;
    end else begin
      rd_vld  <= idle & rd_req;
      wrt_rej <= ~idle & bus_req;

      case (state_q)
        IDLE: begin
          if (wr_req) begin
            addr_q  <= eep_addr;
            data_q  <= wrt_data;
            fail_q  <= 1'b0;
            wrt_err <= 1'b0;
          end else if (rd_req) begin
            rd_data <= mem[eep_addr];
          end
        end
        ARM: begin
          cnt_q <= '0;
          if (!chrg_pmp_en) fail_q <= 1'b1;
        end
        PROG: begin
          // Leaves PROG at CNT_LAST, so the guard only matters as wrap protection.
          if (cnt_q != CNT_LAST) cnt_q <= cnt_q + CNT_W'(1);
          if (!chrg_pmp_en) fail_q <= 1'b1;
        end
        COMMIT: begin
          if (fail_q) wrt_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Word store
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately outside the reset domain: it models
  // non-volatile cells. A reset mid-program forces the FSM out of COMMIT
  // asynchronously, so the commit write below can never fire.
  always_ff @(posedge clk) begin
    if (state_q == COMMIT) mem[addr_q] <= fail_q ? {DATA_W{1'b1}} : data_q;
  end

endmodule

// File: tb/tb_eep_prog_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eep_prog_ctrl
// Directed self-checking bench for eep_prog_ctrl with PUMP_CYCLES=8,
// DATA_W=12, ADDR_W=2. Inputs change 1 time unit after the rising edge and
// outputs are checked there too, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_eep_prog_ctrl;

  localparam int DATA_W      = 12;
  localparam int ADDR_W      = 2;
  localparam int PUMP_CYCLES = 8;
  localparam int BUSY_GOOD   = PUMP_CYCLES + 2;  // ARM + PROG*8 + COMMIT

  logic              clk = 1'b0;
  logic              por_n;
  logic              eep_cs_n;
  logic              eep_r_w_n;
  logic [ADDR_W-1:0] eep_addr;
  logic [DATA_W-1:0] wrt_data;
  logic              chrg_pmp_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_vld;
  logic              busy;
  logic              wrt_done;
  logic              wrt_err;
  logic              wrt_rej;

  int checks = 0;
  int errors = 0;

  eep_prog_ctrl #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .PUMP_CYCLES (PUMP_CYCLES)
  ) dut (
    .clk         (clk),
    .por_n       (por_n),
    .eep_cs_n    (eep_cs_n),
    .eep_r_w_n   (eep_r_w_n),
    .eep_addr    (eep_addr),
    .wrt_data    (wrt_data),
    .chrg_pmp_en (chrg_pmp_en),
    .rd_data     (rd_data),
    .rd_vld      (rd_vld),
    .busy        (busy),
    .wrt_done    (wrt_done),
    .wrt_err     (wrt_err),
    .wrt_rej     (wrt_rej)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a write for one edge; afterwards the bus is idle again.
  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    eep_cs_n  = 1'b0;
    eep_r_w_n = 1'b0;
    eep_addr  = a;
    wrt_data  = d;
    tick();
    eep_cs_n  = 1'b1;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a);
    eep_cs_n  = 1'b0;
    eep_r_w_n = 1'b1;
    eep_addr  = a;
    tick();
    eep_cs_n  = 1'b1;
  endtask

  // Counts busy cycles (from the current one) and wrt_done pulses until idle.
  task automatic wait_idle(output int cycles, output int dones);
    cycles = 0;
    dones  = 0;
    while (busy && cycles < 100) begin
      if (wrt_done) dones++;
      cycles++;
      tick();
    end
  endtask

  int n_busy, n_done;

  initial begin
    por_n       = 1'b0;
    eep_cs_n    = 1'b1;
    eep_r_w_n   = 1'b1;
    eep_addr    = '0;
    wrt_data    = '0;
    chrg_pmp_en = 1'b1;
    #1;
    check("rst_rd_data",  32'(rd_data),  32'h0);
    check("rst_rd_vld",   32'(rd_vld),   32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_wrt_done", 32'(wrt_done), 32'h0);
    check("rst_wrt_err",  32'(wrt_err),  32'h0);
    check("rst_wrt_rej",  32'(wrt_rej),  32'h0);
    tick();
    tick();
    por_n = 1'b1;
    tick();

    // Good write: 0xA5C -> addr 2, pump on throughout.
    bus_write(2'd2, 12'hA5C);
    check("good_busy_next", 32'(busy), 32'h1);
    wait_idle(n_busy, n_done);
    check("good_busy_cycles", 32'(n_busy), 32'(BUSY_GOOD));
    check("good_done_pulses", 32'(n_done), 32'h1);
    check("good_wrt_err",     32'(wrt_err), 32'h0);
    eep_cs_n  = 1'b0;
    eep_r_w_n = 1'b1;
    eep_addr  = 2'd2;
    check("rd_vld_before", 32'(rd_vld), 32'h0);
    tick();
    eep_cs_n = 1'b1;
    check("rd2_vld",  32'(rd_vld),  32'h1);
    check("rd2_data", 32'(rd_data), 32'hA5C);
    tick();
    check("rd2_vld_pulse", 32'(rd_vld),  32'h0);
    check("rd2_hold",      32'(rd_data), 32'hA5C);

    // Pump off at ARM: 0x123 -> addr 1 fails, word erased.
    chrg_pmp_en = 1'b0;
    bus_write(2'd1, 12'h123);
    wait_idle(n_busy, n_done);
    check("arm_fail_busy_cycles", 32'(n_busy), 32'h2);
    check("arm_fail_done",        32'(n_done), 32'h1);
    check("arm_fail_err",         32'(wrt_err), 32'h1);
    chrg_pmp_en = 1'b1;
    bus_read(2'd1);
    check("arm_fail_rd1", 32'(rd_data), 32'hFFF);

    // Pump drops on PROG cycle 5: 0x456 -> addr 3 fails.
    bus_write(2'd3, 12'h456);
    check("prog_fail_err_cleared", 32'(wrt_err), 32'h0);
    tick();                              // ARM -> PROG, counter 0
    for (int i = 0; i < 5; i++) tick();  // PROG cycles 0..4 with pump on
    chrg_pmp_en = 1'b0;                  // PROG cycle 5
    check("prog_fail_still_busy", 32'(busy), 32'h1);
    tick();
    check("prog_fail_commit_done", 32'(wrt_done), 32'h1);
    chrg_pmp_en = 1'b1;
    tick();
    check("prog_fail_idle", 32'(busy),    32'h0);
    check("prog_fail_err",  32'(wrt_err), 32'h1);
    bus_read(2'd3);
    check("prog_fail_rd3", 32'(rd_data), 32'hFFF);
    bus_write(2'd3, 12'h456);
    check("good_clears_err", 32'(wrt_err), 32'h0);
    wait_idle(n_busy, n_done);
    check("rewrite_err", 32'(wrt_err), 32'h0);
    bus_read(2'd3);
    check("rewrite_rd3", 32'(rd_data), 32'h456);

    // Accesses while busy are refused: 0x0F0 -> addr 0.
    bus_write(2'd0, 12'h0F0);            // busy cycle 1
    tick();                              // 2
    tick();                              // 3
    bus_read(2'd1);                      // 4
    check("rej_rd_pulse", 32'(wrt_rej), 32'h1);
    check("rej_rd_vld",   32'(rd_vld),  32'h0);
    check("rej_rd_data",  32'(rd_data), 32'h456);
    tick();                              // 5
    check("rej_pulse_end", 32'(wrt_rej), 32'h0);
    bus_write(2'd2, 12'h111);            // 6
    check("rej_wr_pulse", 32'(wrt_rej), 32'h1);
    wait_idle(n_busy, n_done);
    check("rej_remaining_busy", 32'(n_busy), 32'(BUSY_GOOD - 5));
    check("rej_done",           32'(n_done), 32'h1);
    check("rej_err",            32'(wrt_err), 32'h0);
    bus_read(2'd2);
    check("rej_addr2_kept", 32'(rd_data), 32'hA5C);
    bus_read(2'd0);
    check("rej_addr0_prog", 32'(rd_data), 32'h0F0);

    // Reset mid-PROG of 0x777 -> addr 0.
    bus_write(2'd0, 12'h777);
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_busy", 32'(busy), 32'h1);
    por_n = 1'b0;
    #1;
    check("midrst_rd_data",  32'(rd_data),  32'h0);
    check("midrst_rd_vld",   32'(rd_vld),   32'h0);
    check("midrst_busy",     32'(busy),     32'h0);
    check("midrst_wrt_done", 32'(wrt_done), 32'h0);
    check("midrst_wrt_err",  32'(wrt_err),  32'h0);
    check("midrst_wrt_rej",  32'(wrt_rej),  32'h0);
    tick();
    por_n = 1'b1;
    tick();
    bus_read(2'd0);
    check("midrst_addr0_kept", 32'(rd_data), 32'h0F0);

    // Back-to-back: new write on the cycle after wrt_done.
    bus_write(2'd1, 12'h5A5);
    n_busy = 0;
    while (!wrt_done && n_busy < 100) begin
      n_busy++;
      tick();
    end
    check("b2b_done_seen", 32'(wrt_done), 32'h1);
    tick();
    check("b2b_idle", 32'(busy), 32'h0);
    bus_write(2'd2, 12'h6B6);
    check("b2b_busy_again", 32'(busy), 32'h1);
    wait_idle(n_busy, n_done);
    check("b2b_busy_cycles", 32'(n_busy), 32'(BUSY_GOOD));
    bus_read(2'd1);
    check("b2b_rd1", 32'(rd_data), 32'h5A5);
    bus_read(2'd2);
    check("b2b_rd2", 32'(rd_data), 32'h6B6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
